// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity modes and the baud divisor helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_PARITY  = 3'd3,
        ST_STOP    = 3'd4,
        ST_DELIVER = 3'd5
    } rx_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Clock cycles per oversample tick, rounded to nearest.
    function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
        return (clk_freq + (baud * oversample) / 2) / (baud * oversample);
    endfunction

    // Expected parity bit given the XOR-reduction of the payload.
    function automatic logic parity_of(input logic xor_red, input int mode);
        return (mode == PAR_ODD) ? ~xor_red : xor_red;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Divisor counter emitting a one-cycle tick every DIV clocks; held at zero while clr is high.
module uart_baud_tick #(
    parameter int DIV = 326
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == W'(DIV - 1)) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver with error flags and a one-entry valid/ready holding register.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each bit centre.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 RST,
    input  logic                 RX_Pin_In,
    output logic [DATA_BITS-1:0] RX_Data_Out,
    output logic                 RX_Valid_Out,
    input  logic                 RX_Ready_In,
    output logic                 Parity_Err_Out,
    output logic                 Frame_Err_Out,
    output logic                 Overrun_Err_Out,
    input  logic                 Err_Clr_In,
    output logic                 Busy_Out,
    output rx_state_e            dbg_state
);
    localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int TW  = $clog2(OVERSAMPLE);
    localparam int BCW = $clog2(DATA_BITS);

    rx_state_e            state, state_next;
    logic                 rx_meta, rx_sync, rx_prev;
    logic                 tick, decide, bit_val, fall, load;
    logic [TW-1:0]        os_cnt;
    logic [BCW-1:0]       bit_cnt;
    logic                 stop_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_err, frm_err, wait_high;

    // Handshake: a payload transfers on any cycle where RX_Valid_Out and RX_Ready_In are both high;
    // data and flags stay stable while valid is high and ready is low.

    always_ff @(posedge clk) begin
        if (RST) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= RX_Pin_In;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign fall = rx_prev & ~rx_sync;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst  (RST),
        .clr  (state == ST_IDLE),
        .tick (tick)
    );

    // Oversample index free-runs modulo OVERSAMPLE for the whole frame.
    always_ff @(posedge clk) begin
        if (RST || state == ST_IDLE) begin
            os_cnt <= '0;
        end else if (tick) begin
            os_cnt <= (os_cnt == TW'(OVERSAMPLE - 1)) ? '0 : os_cnt + 1'b1;
        end
    end

    assign decide = tick && (os_cnt == TW'(OVERSAMPLE / 2 + 1));

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] smp;

    always_ff @(posedge clk) begin
        if (RST) begin
            smp <= 2'b11;
        end else if (tick && os_cnt == TW'(OVERSAMPLE / 2 - 1)) begin
            smp[0] <= rx_sync;
        end else if (tick && os_cnt == TW'(OVERSAMPLE / 2)) begin
            smp[1] <= rx_sync;
        end
    end

    assign bit_val = (smp[0] & smp[1]) | (smp[0] & rx_sync) | (smp[1] & rx_sync);
`else
    logic smp;

    always_ff @(posedge clk) begin
        if (RST) begin
            smp <= 1'b1;
        end else if (tick && os_cnt == TW'(OVERSAMPLE / 2)) begin
            smp <= rx_sync;
        end
    end

    assign bit_val = smp;
`endif

    always_ff @(posedge clk) begin
        if (RST) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (fall && !wait_high) state_next = ST_START;
            ST_START:   if (decide) state_next = bit_val ? ST_IDLE : ST_DATA;
            ST_DATA:    if (decide && bit_cnt == BCW'(DATA_BITS - 1))
                            state_next = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            ST_PARITY:  if (decide) state_next = ST_STOP;
            ST_STOP:    if (decide && stop_cnt == 1'(STOP_BITS - 1)) state_next = ST_DELIVER;
            ST_DELIVER: state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
            shreg     <= '0;
            par_err   <= 1'b0;
            frm_err   <= 1'b0;
            wait_high <= 1'b0;
        end else begin
            if (state == ST_IDLE) begin
                bit_cnt  <= '0;
                stop_cnt <= 1'b0;
                par_err  <= 1'b0;
                frm_err  <= 1'b0;
                if (rx_sync) wait_high <= 1'b0;
            end
            if (decide) begin
                case (state)
                    ST_DATA: begin
                        shreg   <= {bit_val, shreg[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    ST_PARITY: par_err <= (bit_val != parity_of(^shreg, PARITY));
                    ST_STOP: begin
                        stop_cnt <= stop_cnt + 1'b1;
                        if (!bit_val) frm_err <= 1'b1;
                    end
                    default: ;
                endcase
            end
            // A break leaves the line low; hold off re-arming until it is seen high.
            if (state == ST_DELIVER && frm_err) wait_high <= 1'b1;
        end
    end

    assign load = (state == ST_DELIVER) && (!RX_Valid_Out || RX_Ready_In);

    always_ff @(posedge clk) begin
        if (RST) begin
            RX_Data_Out     <= '0;
            RX_Valid_Out    <= 1'b0;
            Parity_Err_Out  <= 1'b0;
            Frame_Err_Out   <= 1'b0;
            Overrun_Err_Out <= 1'b0;
        end else begin
            if (load) begin
                RX_Data_Out    <= shreg;
                Parity_Err_Out <= par_err;
                Frame_Err_Out  <= frm_err;
                RX_Valid_Out   <= 1'b1;
            end else if (RX_Valid_Out && RX_Ready_In) begin
                RX_Valid_Out <= 1'b0;
            end
            if (state == ST_DELIVER && RX_Valid_Out && !RX_Ready_In) Overrun_Err_Out <= 1'b1;
            else if (Err_Clr_In)                                      Overrun_Err_Out <= 1'b0;
        end
    end

    assign Busy_Out  = (state != ST_IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three instances (8N1, 8E1, 7O2) at 32 clocks per bit.
`timescale 1ns/1ps
module tb_uart_rx_cfg;
    import uart_pkg::*;

    localparam int CLK_HZ   = 3200000;
    localparam int BAUD_R   = 100000;
    localparam int OS       = 16;
    localparam int BIT_CLKS = 32;
    localparam int NV       = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       err_clr;
    logic [2:0] rx_line;
    logic [2:0] ready;
    wire  [7:0] dout0, dout1;
    wire  [6:0] dout2;
    wire  [2:0] valid, pe, fe, ovr, busy;
    rx_state_e  st0, st1, st2;

    int checks = 0;
    int failures = 0;
    int vhi[3] = '{0, 0, 0};
    logic [10:0] exp_q0[$], exp_q1[$], exp_q2[$];

    typedef struct {
        int         inst;
        logic [8:0] data;
        logic       par;
        logic [1:0] stops;
        logic [8:0] exp_data;
        logic       exp_pe;
        logic       exp_fe;
    } vec_t;
    vec_t vecs[NV];

    always #5 clk = ~clk;

    uart_rx_cfg #(.CLK_FREQ(CLK_HZ), .BAUD(BAUD_R), .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .RST(rst), .RX_Pin_In(rx_line[0]), .RX_Data_Out(dout0), .RX_Valid_Out(valid[0]),
        .RX_Ready_In(ready[0]), .Parity_Err_Out(pe[0]), .Frame_Err_Out(fe[0]), .Overrun_Err_Out(ovr[0]),
        .Err_Clr_In(err_clr), .Busy_Out(busy[0]), .dbg_state(st0));

    uart_rx_cfg #(.CLK_FREQ(CLK_HZ), .BAUD(BAUD_R), .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
        .clk(clk), .RST(rst), .RX_Pin_In(rx_line[1]), .RX_Data_Out(dout1), .RX_Valid_Out(valid[1]),
        .RX_Ready_In(ready[1]), .Parity_Err_Out(pe[1]), .Frame_Err_Out(fe[1]), .Overrun_Err_Out(ovr[1]),
        .Err_Clr_In(err_clr), .Busy_Out(busy[1]), .dbg_state(st1));

    uart_rx_cfg #(.CLK_FREQ(CLK_HZ), .BAUD(BAUD_R), .OVERSAMPLE(OS), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u2 (
        .clk(clk), .RST(rst), .RX_Pin_In(rx_line[2]), .RX_Data_Out(dout2), .RX_Valid_Out(valid[2]),
        .RX_Ready_In(ready[2]), .Parity_Err_Out(pe[2]), .Frame_Err_Out(fe[2]), .Overrun_Err_Out(ovr[2]),
        .Err_Clr_In(err_clr), .Busy_Out(busy[2]), .dbg_state(st2));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_pop(input int idx, input logic [10:0] act);
        logic [10:0] e;
        bit have;
        have = 0;
        e = '0;
        case (idx)
            0: if (exp_q0.size() > 0) begin e = exp_q0.pop_front(); have = 1; end
            1: if (exp_q1.size() > 0) begin e = exp_q1.pop_front(); have = 1; end
            default: if (exp_q2.size() > 0) begin e = exp_q2.pop_front(); have = 1; end
        endcase
        checks++;
        if (!have) begin
            failures++;
            $display("FAIL unexpected_valid inst=%0d got pe/fe/data=%h at %0t", idx, act, $time);
        end else if (act !== e) begin
            failures++;
            $display("FAIL rx_frame inst=%0d got pe/fe/data=%h want=%h at %0t", idx, act, e, $time);
        end
    endtask

    function automatic void push_exp(input int inst, input logic [8:0] d, input logic p, input logic f);
        case (inst)
            0: exp_q0.push_back({p, f, d});
            1: exp_q1.push_back({p, f, d});
            default: exp_q2.push_back({p, f, d});
        endcase
    endfunction

    // Monitor: sample away from the active edge and score every handshake.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) if (valid[i]) vhi[i]++;
        if (valid[0] && ready[0]) check_pop(0, {pe[0], fe[0], 1'b0, dout0});
        if (valid[1] && ready[1]) check_pop(1, {pe[1], fe[1], 1'b0, dout1});
        if (valid[2] && ready[2]) check_pop(2, {pe[2], fe[2], 2'b00, dout2});
    end

    task automatic wait_clks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input int inst, input logic b);
        rx_line[inst] = b;
        wait_clks(BIT_CLKS);
    endtask

    task automatic send_frame(input int inst, input logic [8:0] data, input logic par,
                              input logic [1:0] stops, input logic end_level);
        int nb;
        nb = (inst == 2) ? 7 : 8;
        drive_bit(inst, 1'b0);
        for (int i = 0; i < nb; i++) drive_bit(inst, data[i]);
        if (inst != 0) drive_bit(inst, par);
        for (int s = 0; s < ((inst == 2) ? 2 : 1); s++) drive_bit(inst, stops[s]);
        rx_line[inst] = end_level;
    endtask

    initial begin
        int b;
        logic [7:0] r;

        vecs[0] = '{0, 9'h0A5, 1'b0, 2'b11, 9'h0A5, 1'b0, 1'b0};
        vecs[1] = '{0, 9'h000, 1'b0, 2'b11, 9'h000, 1'b0, 1'b0};
        vecs[2] = '{0, 9'h0FF, 1'b0, 2'b11, 9'h0FF, 1'b0, 1'b0};
        vecs[3] = '{0, 9'h055, 1'b0, 2'b10, 9'h055, 1'b0, 1'b1};
        vecs[4] = '{1, 9'h03C, 1'b1, 2'b11, 9'h03C, 1'b1, 1'b0};
        vecs[5] = '{1, 9'h03C, 1'b0, 2'b11, 9'h03C, 1'b0, 1'b0};
        vecs[6] = '{1, 9'h081, 1'b1, 2'b10, 9'h081, 1'b1, 1'b1};
        vecs[7] = '{2, 9'h05A, 1'b1, 2'b11, 9'h05A, 1'b0, 1'b0};
        vecs[8] = '{2, 9'h05A, 1'b1, 2'b01, 9'h05A, 1'b0, 1'b1};
        vecs[9] = '{2, 9'h05A, 1'b0, 2'b11, 9'h05A, 1'b1, 1'b0};

        // Reset state
        rst = 1'b1; err_clr = 1'b0; rx_line = 3'b111; ready = 3'b111;
        wait_clks(4);
        check("rst_valid", {29'd0, valid}, 32'd0);
        check("rst_data0", {24'd0, dout0}, 32'd0);
        check("rst_data2", {25'd0, dout2}, 32'd0);
        check("rst_pe_fe", {26'd0, pe, fe}, 32'd0);
        check("rst_ovr", {29'd0, ovr}, 32'd0);
        check("rst_busy", {29'd0, busy}, 32'd0);
        check("rst_state0", {29'd0, st0}, {29'd0, ST_IDLE});
        rst = 1'b0;
        wait_clks(8);

        // Table-driven frames
        for (int v = 0; v < NV; v++) begin
            b = vhi[vecs[v].inst];
            push_exp(vecs[v].inst, vecs[v].exp_data, vecs[v].exp_pe, vecs[v].exp_fe);
            send_frame(vecs[v].inst, vecs[v].data, vecs[v].par, vecs[v].stops, 1'b1);
            wait_clks(24);
            check("valid_one_cycle", vhi[vecs[v].inst] - b, 1);
            check("busy_after", {31'd0, busy[vecs[v].inst]}, 32'd0);
        end

        // Random payloads on 8N1 and 8E1
        for (int k = 0; k < 4; k++) begin
            r = 8'($urandom_range(0, 255));
            push_exp(0, {1'b0, r}, 1'b0, 1'b0);
            send_frame(0, {1'b0, r}, 1'b0, 2'b11, 1'b1);
            wait_clks(16);
            r = 8'($urandom_range(0, 255));
            push_exp(1, {1'b0, r}, 1'b0, 1'b0);
            send_frame(1, {1'b0, r}, ^r, 2'b11, 1'b1);
            wait_clks(16);
        end

        // Frame error followed by a line held low for 3 bit times
        b = vhi[0];
        push_exp(0, 9'h055, 1'b0, 1'b1);
        send_frame(0, 9'h055, 1'b0, 2'b00, 1'b0);
        wait_clks(3 * BIT_CLKS);
        check("break_one_valid", vhi[0] - b, 1);
        check("break_not_busy", {31'd0, busy[0]}, 32'd0);
        rx_line[0] = 1'b1;
        wait_clks(40);
        check("break_no_more_valid", vhi[0] - b, 1);
        push_exp(0, 9'h033, 1'b0, 1'b0);
        send_frame(0, 9'h033, 1'b0, 2'b11, 1'b1);
        wait_clks(24);
        check("break_rearm", vhi[0] - b, 2);

        // Overrun with consumer stalled
        ready[0] = 1'b0;
        push_exp(0, 9'h011, 1'b0, 1'b0);
        send_frame(0, 9'h011, 1'b0, 2'b11, 1'b1);
        wait_clks(24);
        check("hold_valid", {31'd0, valid[0]}, 32'd1);
        check("hold_data", {24'd0, dout0}, 32'h11);
        check("no_ovr_yet", {31'd0, ovr[0]}, 32'd0);
        send_frame(0, 9'h022, 1'b0, 2'b11, 1'b1);
        wait_clks(24);
        check("ovr_data_kept", {24'd0, dout0}, 32'h11);
        check("ovr_set", {31'd0, ovr[0]}, 32'd1);
        ready[0] = 1'b1;
        wait_clks(4);
        check("ovr_valid_drop", {31'd0, valid[0]}, 32'd0);
        check("ovr_sticky", {31'd0, ovr[0]}, 32'd1);
        err_clr = 1'b1;
        wait_clks(1);
        err_clr = 1'b0;
        wait_clks(1);
        check("ovr_cleared", {31'd0, ovr[0]}, 32'd0);

        // Short low glitch on an idle line
        b = vhi[0];
        rx_line[0] = 1'b0;
        wait_clks(3);
        rx_line[0] = 1'b1;
        wait_clks(BIT_CLKS);
        check("glitch_busy_clear", {31'd0, busy[0]}, 32'd0);
        wait_clks(BIT_CLKS * 4);
        check("glitch_no_valid", vhi[0] - b, 0);

        // Reset in the middle of a 7O2 data bit
        b = vhi[2];
        drive_bit(2, 1'b0);
        drive_bit(2, 1'b0);
        rx_line[2] = 1'b1;
        wait_clks(BIT_CLKS / 2);
        rst = 1'b1;
        wait_clks(1);
        rst = 1'b0;
        check("midrst_busy", {31'd0, busy[2]}, 32'd0);
        check("midrst_data", {25'd0, dout2}, 32'd0);
        check("midrst_flags", {29'd0, valid[2], pe[2], fe[2]}, 32'd0);
        wait_clks(BIT_CLKS * 12);
        check("midrst_no_valid", vhi[2] - b, 0);
        check("midrst_idle", {29'd0, st2}, {29'd0, ST_IDLE});

        check("q0_drained", exp_q0.size(), 0);
        check("q1_drained", exp_q1.size(), 0);
        check("q2_drained", exp_q2.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised UART receiver, the next generation of the fixed 8N1 receiver in uart_top. Adds configurable data width, parity, stop bits and oversampling, plus error flags and a valid/ready output handshake with a one-entry holding register. It sits between RX_Pin_In and the consumer logic (LED/loopback/TX path).

Parameters:
CLK_FREQ, 50000000, system clock in Hz
BAUD, 9600, line rate in bit/s
OVERSAMPLE, 16, ticks per bit; even, >=8
DATA_BITS, 8, payload bits, 5..9, LSB first
PARITY, 0, 0=none, 1=odd, 2=even
STOP_BITS, 1, 1 or 2

Ports:
clk  in  1  system clock
RST  in  1  synchronous, active-high reset
RX_Pin_In  in  1  asynchronous serial line, idle high
RX_Data_Out  out  DATA_BITS  received payload
RX_Valid_Out  out  1  payload and flags valid
RX_Ready_In  in  1  consumer accepts when high with valid
Parity_Err_Out  out  1  parity mismatch for the current payload
Frame_Err_Out  out  1  stop bit sampled low for the current payload
Overrun_Err_Out  out  1  sticky: a frame was dropped
Err_Clr_In  in  1  clears Overrun_Err_Out
Busy_Out  out  1  frame in progress (state != IDLE)

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (RST).
- Reset: all outputs 0; synchroniser flops preset to 1; state IDLE; tick counter 0.
- RX_Pin_In goes through a 2-flop synchroniser. All sampling uses the synchronised value.
- Tick divisor DIV = (CLK_FREQ + BAUD*OVERSAMPLE/2) / (BAUD*OVERSAMPLE), rounded to nearest. Defaults give 326.
- The tick counter runs only outside IDLE. It restarts at 0 on start-edge detect.
- Sample point is tick index OVERSAMPLE/2 of each bit.
- States:
  - IDLE: a synchronised falling edge moves to START.
  - START: at the sample point, line low moves to DATA. Line high is a false start and returns to IDLE.
  - DATA: shift LSB first for DATA_BITS bits, then go to PARITY if PARITY!=0, else STOP.
  - PARITY: compare the sampled bit with odd/even parity of the payload.
  - STOP: sample STOP_BITS stop bits. Any low sample sets the frame error. After the last stop sample go to DELIVER.
  - DELIVER: one cycle, then IDLE.
- Break/stuck-low line: after a frame error, IDLE does not re-arm until the line has been sampled high for 1 clk.
- Output handshake:
  - The holding register accepts a frame in DELIVER if RX_Valid_Out==0, or if RX_Valid_Out & RX_Ready_In in that same cycle.
  - RX_Valid_Out rises the cycle after DELIVER.
  - Latency: the last stop-bit sample point plus 2 clk to valid.
  - Data and both error flags update together and are held stable while valid is high and ready is low.
  - RX_Valid_Out falls the cycle after a valid&ready handshake, unless a new frame loads in that same cycle.
- Overrun: if a frame is in DELIVER while valid is high and ready is low, drop the new frame and keep the old one. Overrun_Err_Out sets the next cycle and stays high until Err_Clr_In is high. If set and clear happen in the same cycle, set wins.
- Reset mid-frame: the partial frame is discarded and no valid is produced.

Optional Feature:
- Macro UART_RX_MAJORITY_EN.
- Defined: each bit is sampled at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1, and the 2-of-3 majority is used. This applies to start, data, parity and stop bits.
- Undefined: a single sample at OVERSAMPLE/2.
- Decision timing is identical in both builds: the decision is taken at tick OVERSAMPLE/2+1.

Decomposition:
- Package uart_pkg holds:
  - state encoding localparams (IDLE, START, DATA, PARITY, STOP, DELIVER);
  - PARITY mode constants PAR_NONE/PAR_ODD/PAR_EVEN;
  - a constant function for the DIV calculation, shared with the future TX.
- One sub-module, uart_baud_tick: divisor counter with sync clear, emitting a 1-clk tick pulse. It will be reused by the TX side.

Test Plan:
- 9600 8N1 with defaults, send 0xA5 at a bit period of 104167 ns. Expect RX_Data_Out=0xA5 and valid 1 clk, with both error flags 0 and Busy_Out low after delivery.
- PARITY=2, send 0x3C with parity bit 1 (wrong). Expect data 0x3C and Parity_Err_Out=1. Resend with parity 0: expect Parity_Err_Out=0.
- Stop bit driven low on 0x55. Expect data 0x55 and Frame_Err_Out=1. Hold the line low for 3 bit times: no further valid until the line returns high.
- RX_Ready_In=0, send 0x11 then 0x22. Expect RX_Data_Out stays 0x11 and Overrun_Err_Out=1. Pulse Err_Clr_In: expect the flag clears.
- 2 µs low glitch on an idle line. Expect no valid, and Busy_Out returns to 0 within one bit time.
- DATA_BITS=7, PARITY=1, STOP_BITS=2, send 0x5A. Expect a 7-bit payload 0x5A with no errors. Then assert RST mid-data-bit: expect no valid and all outputs 0.
